// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: mult/div sequencer states, op and cause encodings.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        WRITE,
        EXC
    } muldiv_state_t;

    localparam logic MD_OP_MULT    = 1'b0;
    localparam logic MD_OP_DIV     = 1'b1;

    localparam logic MD_CAUSE_ZERO = 1'b0;
    localparam logic MD_CAUSE_TMO  = 1'b1;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared Mult/Div units: start pulse, watchdog-bounded wait,
// High/Low write on success, single-cycle exception pulse on div-by-zero or timeout.
module muldiv_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic op,
    input  logic StopMult,
    input  logic DivStop,
    input  logic DivZero,
    output logic StartMult,
    output logic StartDiv,
    output logic DivMultMux,
    output logic RegHighW,
    output logic RegLowW,
    output logic busy,
    output logic done,
    output logic div_zero_exc,
    output logic timeout_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    muldiv_state_t r_state, w_state_next;
    logic          r_op, w_op_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_cause, w_cause_next;
    logic          w_stop;

    // Only the selected unit's completion counts.
    assign w_stop = (r_op == MD_OP_DIV) ? DivStop : StopMult;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_op    <= 1'b0;
            r_cnt   <= '0;
            r_cause <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_op    <= w_op_next;
            r_cnt   <= w_cnt_next;
            r_cause <= w_cause_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op;
        w_cnt_next   = r_cnt;
        w_cause_next = r_cause;
        StartMult    = 1'b0;
        StartDiv     = 1'b0;
        DivMultMux   = 1'b0;
        RegHighW     = 1'b0;
        RegLowW      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        div_zero_exc = 1'b0;
        timeout_err  = 1'b0;

        case (r_state)
            IDLE: begin
                if (req) begin
                    w_op_next    = op;
                    w_state_next = START;
                end
            end
            START: begin
                busy         = 1'b1;
                StartMult    = (r_op == MD_OP_MULT);
                StartDiv     = (r_op == MD_OP_DIV);
                w_cnt_next   = '0;
                w_state_next = WAIT;
            end
            WAIT: begin
                busy       = 1'b1;
                DivMultMux = ~r_op;
                // Zero beats stop, and stop beats the watchdog on its last cycle.
                if ((r_op == MD_OP_DIV) && DivZero) begin
                    w_cause_next = MD_CAUSE_ZERO;
                    w_state_next = EXC;
                end else if (w_stop) begin
                    w_state_next = WRITE;
                end else if (r_cnt == CNT_LAST) begin
                    w_cause_next = MD_CAUSE_TMO;
                    w_state_next = EXC;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            WRITE: begin
                busy         = 1'b1;
                DivMultMux   = ~r_op;
                RegHighW     = 1'b1;
                RegLowW      = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            EXC: begin
                busy         = 1'b1;
                div_zero_exc = (r_cause == MD_CAUSE_ZERO);
                timeout_err  = (r_cause == MD_CAUSE_TMO);
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: per-cycle vector table on a TIMEOUT=4 instance,
// plus generated sequences on a default TIMEOUT=40 instance.
module tb_muldiv_ctrl;

    // Output vector order: StartMult StartDiv DivMultMux RegHighW RegLowW busy done div_zero_exc timeout_err
    localparam logic [8:0] E_IDLE  = 9'b000000000;
    localparam logic [8:0] E_S_M   = 9'b100001000;
    localparam logic [8:0] E_S_D   = 9'b010001000;
    localparam logic [8:0] E_W_M   = 9'b001001000;
    localparam logic [8:0] E_W_D   = 9'b000001000;
    localparam logic [8:0] E_WR_M  = 9'b001111100;
    localparam logic [8:0] E_WR_D  = 9'b000111100;
    localparam logic [8:0] E_EXC_Z = 9'b000001010;
    localparam logic [8:0] E_EXC_T = 9'b000001001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: TIMEOUT=4
    logic a_rst, a_req, a_op, a_sm, a_ds, a_dz;
    logic a_smo, a_sdo, a_mux, a_hw, a_lw, a_busy, a_done, a_zexc, a_tmo;
    logic [8:0] a_out;
    assign a_out = {a_smo, a_sdo, a_mux, a_hw, a_lw, a_busy, a_done, a_zexc, a_tmo};

    muldiv_ctrl #(.TIMEOUT(4)) dut_a (
        .clock(clk), .reset(a_rst), .req(a_req), .op(a_op),
        .StopMult(a_sm), .DivStop(a_ds), .DivZero(a_dz),
        .StartMult(a_smo), .StartDiv(a_sdo), .DivMultMux(a_mux),
        .RegHighW(a_hw), .RegLowW(a_lw), .busy(a_busy), .done(a_done),
        .div_zero_exc(a_zexc), .timeout_err(a_tmo)
    );

    // Instance B: default TIMEOUT=40
    logic b_rst, b_req, b_op, b_sm, b_ds, b_dz;
    logic b_smo, b_sdo, b_mux, b_hw, b_lw, b_busy, b_done, b_zexc, b_tmo;
    logic [8:0] b_out;
    assign b_out = {b_smo, b_sdo, b_mux, b_hw, b_lw, b_busy, b_done, b_zexc, b_tmo};

    muldiv_ctrl dut_b (
        .clock(clk), .reset(b_rst), .req(b_req), .op(b_op),
        .StopMult(b_sm), .DivStop(b_ds), .DivZero(b_dz),
        .StartMult(b_smo), .StartDiv(b_sdo), .DivMultMux(b_mux),
        .RegHighW(b_hw), .RegLowW(b_lw), .busy(b_busy), .done(b_done),
        .div_zero_exc(b_zexc), .timeout_err(b_tmo)
    );

    typedef struct {
        string      tag;
        logic       rst;
        logic       req;
        logic       op;
        logic       sm;
        logic       ds;
        logic       dz;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string tag, logic rst, logic req, logic op,
                                logic sm, logic ds, logic dz, logic [8:0] exp);
        vec_t v;
        v.tag = tag; v.rst = rst; v.req = req; v.op = op;
        v.sm = sm; v.ds = ds; v.dz = dz; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int idx, logic [8:0] act, logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] outputs=%b required=%b", name, idx, act, exp);
        end else begin
            $display("ok   %s[%0d] outputs=%b", name, idx, act);
        end
    endtask

    // Drives one operation on instance B; stop_cyc=0 means the unit never completes.
    task automatic run_b(string name, logic op, int stop_cyc);
        int last_wait;
        int c;
        logic [8:0] exp;
        last_wait = (stop_cyc > 0) ? stop_cyc : 41;
        for (c = 0; c <= last_wait + 2; c++) begin
            @(negedge clk);
            b_req = (c == 0);
            b_op  = op;
            b_sm  = (stop_cyc > 0) && (c == stop_cyc) && !op;
            b_ds  = (stop_cyc > 0) && (c == stop_cyc) && op;
            #1;
            if (c == 0)                 exp = E_IDLE;
            else if (c == 1)            exp = op ? E_S_D : E_S_M;
            else if (c <= last_wait)    exp = op ? E_W_D : E_W_M;
            else if (c == last_wait + 1)
                exp = (stop_cyc > 0) ? (op ? E_WR_D : E_WR_M) : E_EXC_T;
            else                        exp = E_IDLE;
            check(name, c, b_out, exp);
        end
        b_req = 1'b0; b_sm = 1'b0; b_ds = 1'b0;
    endtask

    initial begin
        a_rst = 1'b1; a_req = 1'b0; a_op = 1'b0; a_sm = 1'b0; a_ds = 1'b0; a_dz = 1'b0;
        b_rst = 1'b1; b_req = 1'b0; b_op = 1'b0; b_sm = 1'b0; b_ds = 1'b0; b_dz = 1'b0;

        // Timeout, MULT without stop: WAIT cycles 2..5, timeout_err at 6
        add("tmo", 0, 1, 0, 0, 0, 0, E_IDLE);
        add("tmo", 0, 0, 0, 0, 0, 0, E_S_M);
        for (int i = 0; i < 4; i++) add("tmo", 0, 0, 0, 0, 0, 0, E_W_M);
        add("tmo", 0, 0, 0, 0, 0, 0, E_EXC_T);
        add("tmo", 0, 0, 0, 0, 0, 0, E_IDLE);
        // Stop in the last WAIT cycle beats the watchdog
        add("lastwin", 0, 1, 0, 0, 0, 0, E_IDLE);
        add("lastwin", 0, 0, 0, 0, 0, 0, E_S_M);
        for (int i = 0; i < 3; i++) add("lastwin", 0, 0, 0, 0, 0, 0, E_W_M);
        add("lastwin", 0, 0, 0, 1, 0, 0, E_W_M);
        add("lastwin", 0, 0, 0, 0, 0, 0, E_WR_M);
        add("lastwin", 0, 0, 0, 0, 0, 0, E_IDLE);
        // DIV: zero and stop together in the 3rd WAIT cycle, exception wins
        add("divzero", 0, 1, 1, 0, 0, 0, E_IDLE);
        add("divzero", 0, 0, 0, 0, 0, 0, E_S_D);
        add("divzero", 0, 0, 0, 0, 0, 0, E_W_D);
        add("divzero", 0, 0, 0, 0, 0, 0, E_W_D);
        add("divzero", 0, 0, 0, 0, 1, 1, E_W_D);
        add("divzero", 0, 0, 0, 0, 0, 0, E_EXC_Z);
        add("divzero", 0, 0, 0, 0, 0, 0, E_IDLE);
        // DivZero during MULT is ignored
        add("multdz", 0, 1, 0, 0, 0, 0, E_IDLE);
        add("multdz", 0, 0, 0, 0, 0, 1, E_S_M);
        add("multdz", 0, 0, 0, 0, 0, 1, E_W_M);
        add("multdz", 0, 0, 0, 1, 0, 1, E_W_M);
        add("multdz", 0, 0, 0, 0, 0, 0, E_WR_M);
        add("multdz", 0, 0, 0, 0, 0, 0, E_IDLE);
        // StopMult during DIV is ignored; DivStop in START is ignored
        add("divsm", 0, 1, 1, 0, 0, 0, E_IDLE);
        add("divsm", 0, 0, 0, 0, 1, 0, E_S_D);
        add("divsm", 0, 0, 0, 1, 0, 0, E_W_D);
        add("divsm", 0, 0, 0, 0, 1, 0, E_W_D);
        add("divsm", 0, 0, 0, 0, 0, 0, E_WR_D);
        add("divsm", 0, 0, 0, 0, 0, 0, E_IDLE);
        // req while busy is dropped: exactly one done
        add("busyreq", 0, 1, 0, 0, 0, 0, E_IDLE);
        add("busyreq", 0, 1, 1, 0, 0, 0, E_S_M);
        add("busyreq", 0, 1, 1, 0, 0, 0, E_W_M);
        add("busyreq", 0, 1, 0, 1, 0, 0, E_W_M);
        add("busyreq", 0, 1, 0, 0, 0, 0, E_WR_M);
        add("busyreq", 0, 0, 0, 0, 0, 0, E_IDLE);
        add("busyreq", 0, 0, 0, 0, 0, 0, E_IDLE);
        // Reset mid-WAIT, late stop ignored, then a clean minimum-latency op
        add("rstwait", 0, 1, 0, 0, 0, 0, E_IDLE);
        add("rstwait", 0, 0, 0, 0, 0, 0, E_S_M);
        add("rstwait", 0, 0, 0, 0, 0, 0, E_W_M);
        add("rstwait", 1, 0, 0, 0, 0, 0, E_W_M);
        add("rstwait", 0, 0, 0, 1, 0, 0, E_IDLE);
        add("rstwait", 0, 0, 0, 0, 0, 0, E_IDLE);
        add("rstwait", 0, 1, 0, 0, 0, 0, E_IDLE);
        add("rstwait", 0, 0, 0, 0, 0, 0, E_S_M);
        add("rstwait", 0, 0, 0, 1, 0, 0, E_W_M);
        add("rstwait", 0, 0, 0, 0, 0, 0, E_WR_M);
        add("rstwait", 0, 0, 0, 0, 0, 0, E_IDLE);

        repeat (2) @(negedge clk);
        #1;
        check("reset_a", 0, a_out, E_IDLE);
        check("reset_b", 0, b_out, E_IDLE);
        a_rst = 1'b0;
        b_rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            a_rst = vecs[i].rst;
            a_req = vecs[i].req;
            a_op  = vecs[i].op;
            a_sm  = vecs[i].sm;
            a_ds  = vecs[i].ds;
            a_dz  = vecs[i].dz;
            #1;
            check(vecs[i].tag, i, a_out, vecs[i].exp);
        end
        @(negedge clk);
        a_rst = 1'b0; a_req = 1'b0; a_sm = 1'b0; a_ds = 1'b0; a_dz = 1'b0;

        run_b("mult_nom", 1'b0, 34);
        run_b("div_tmo40", 1'b1, 0);
        run_b("div_last40", 1'b1, 41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
